// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// parity mode encodings and the expected-parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } rxState_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      ODD  = 2'd1,
      EVEN = 2'd2
   } parity_e;

   // Value the parity bit must carry so that data plus parity has the
   // requested number of ones (odd or even).
   function automatic logic expParity(input logic [7:0] data, input parity_e mode);
      logic p;
      p = ^data;
      if (mode == ODD) begin
         p = ~p;
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Byte-level UART receiver: input synchroniser, start/data/parity/stop
// sequencing and bit-centre timing. Reports each finished frame as exactly
// one of byteOk_o, frameErr_o or parityErr_o, on the stop-bit sample cycle.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_GOAL = 434,
   parameter int PARITY   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd_i,
   output logic [7:0] rxByte_o,
   output logic       byteOk_o,
   output logic       frameErr_o,
   output logic       parityErr_o
);

   localparam int            CW      = $clog2(CLK_GOAL + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLK_GOAL - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_GOAL / 2 - 1);
   localparam parity_e       PMODE   = parity_e'(PARITY);

   logic          sync1_q;
   logic          sync2_q;
   logic          rxdPrev_q;
   rxState_e      state_q,   state_d;
   logic [CW-1:0] clkCnt_q,  clkCnt_d;
   logic [2:0]    bitIdx_q,  bitIdx_d;
   logic [7:0]    shift_q,   shift_d;
   logic          parBad_q,  parBad_d;
   logic          errWait_q, errWait_d;

   // Two-flop synchroniser plus one extra stage so a falling edge can be seen;
   // all stages rest at the idle-high line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rxdPrev_q <= 1'b1;
      end else begin
         sync1_q   <= rxd_i;
         sync2_q   <= sync1_q;
         rxdPrev_q <= sync2_q;
      end
   end

   // Receiver state, bit-timing counter and assembled byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         clkCnt_q  <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
         parBad_q  <= 1'b0;
         errWait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clkCnt_q  <= clkCnt_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
         parBad_q  <= parBad_d;
         errWait_q <= errWait_d;
      end
   end

   // Frame sequencing: the start bit is checked at its centre, every later
   // bit one bit time after the previous sample. A parity mismatch is only
   // remembered until the stop bit so each frame raises a single outcome,
   // and a bad stop bit parks in STOP until the line goes high again.
   always_comb begin
      state_d     = state_q;
      clkCnt_d    = clkCnt_q + 1'b1;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      parBad_d    = parBad_q;
      errWait_d   = errWait_q;
      byteOk_o    = 1'b0;
      frameErr_o  = 1'b0;
      parityErr_o = 1'b0;
      case (state_q)
         IDLE: begin
            clkCnt_d  = '0;
            bitIdx_d  = '0;
            parBad_d  = 1'b0;
            errWait_d = 1'b0;
            if (rxdPrev_q && !sync2_q) begin
               state_d = START;
            end
         end
         START: begin
            if (clkCnt_q == HALF_M1) begin
               clkCnt_d = '0;
               state_d  = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clkCnt_q == FULL_M1) begin
               clkCnt_d = '0;
               shift_d  = {sync2_q, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
                  state_d = (PMODE != NONE) ? PAR : STOP;
               end
            end
         end
         PAR: begin
            if (clkCnt_q == FULL_M1) begin
               clkCnt_d = '0;
               parBad_d = (sync2_q != expParity(shift_q, PMODE));
               state_d  = STOP;
            end
         end
         STOP: begin
            if (errWait_q) begin
               clkCnt_d = '0;
               if (sync2_q) begin
                  state_d = IDLE;
               end
            end else if (clkCnt_q == FULL_M1) begin
               clkCnt_d = '0;
               if (!sync2_q) begin
                  frameErr_o = 1'b1;
                  errWait_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  if (parBad_q) begin
                     parityErr_o = 1'b1;
                  end else begin
                     byteOk_o = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rxByte_o = shift_q;

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into BYTES-wide words. Holds the partial word,
// publishes a complete word with a one-cycle valid pulse, drops partial
// words on line errors or when the line stays idle too long.
module uart_rx_packer
   import uart_pkg::*;
#(
   parameter int CLK_F         = 50_000_000,
   parameter int UART_BPS      = 115200,
   parameter int CLK_GOAL      = CLK_F / UART_BPS,
   parameter int BYTES         = 8,
   parameter int MSB_FIRST     = 0,
   parameter int PARITY        = 0,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         uart_rxd,
   output logic [8*BYTES-1:0]           data_out,
   output logic                         data_valid,
   output logic                         frame_err,
   output logic                         parity_err,
   output logic                         timeout_err,
   output logic [$clog2(BYTES+1)-1:0]   byte_cnt
);

   localparam int             BCW        = $clog2(BYTES + 1);
   localparam int             FRAME_BITS = (PARITY != 0) ? 11 : 10;
   localparam int             TO_LIMIT   = TIMEOUT_BYTES * FRAME_BITS * CLK_GOAL;
   localparam int             ICW        = $clog2(TO_LIMIT + 2);
   localparam logic [ICW-1:0] TO_LAST    = ICW'((TO_LIMIT > 0) ? (TO_LIMIT - 1) : 0);
   localparam logic [BCW-1:0] LAST_SLOT  = BCW'(BYTES - 1);

   logic [7:0]         rxByte;
   logic               byteOk;
   logic               frameErrRaw;
   logic               parityErrRaw;

   logic [BCW-1:0]     byteCnt_q,    byteCnt_d;
   logic [8*BYTES-1:0] wordBuf_q,    wordBuf_d;
   logic [8*BYTES-1:0] dataOut_q,    dataOut_d;
   logic               dataValid_q,  dataValid_d;
   logic               frameErr_q,   frameErr_d;
   logic               parityErr_q,  parityErr_d;
   logic               timeoutErr_q, timeoutErr_d;
   logic [ICW-1:0]     idleCnt_q,    idleCnt_d;
   logic [8*BYTES-1:0] wordPlaced;
   logic               timeoutHit;

   uart_rx_core #(
      .CLK_GOAL (CLK_GOAL),
      .PARITY   (PARITY)
   ) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .rxd_i       (uart_rxd),
      .rxByte_o    (rxByte),
      .byteOk_o    (byteOk),
      .frameErr_o  (frameErrRaw),
      .parityErr_o (parityErrRaw)
   );

   // Packer, idle counter and output registers; everything visible on the
   // ports comes straight from these flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byteCnt_q    <= '0;
         wordBuf_q    <= '0;
         dataOut_q    <= '0;
         dataValid_q  <= 1'b0;
         frameErr_q   <= 1'b0;
         parityErr_q  <= 1'b0;
         timeoutErr_q <= 1'b0;
         idleCnt_q    <= '0;
      end else begin
         byteCnt_q    <= byteCnt_d;
         wordBuf_q    <= wordBuf_d;
         dataOut_q    <= dataOut_d;
         dataValid_q  <= dataValid_d;
         frameErr_q   <= frameErr_d;
         parityErr_q  <= parityErr_d;
         timeoutErr_q <= timeoutErr_d;
         idleCnt_q    <= idleCnt_d;
      end
   end

   // Word assembly. Line errors beat everything, an accepted byte beats a
   // simultaneous timeout (and restarts the idle count), and only a finished
   // word is copied to the output so partial data never shows on data_out.
   always_comb begin
      wordPlaced = wordBuf_q;
      for (int k = 0; k < BYTES; k++) begin
         if (byteCnt_q == BCW'(k)) begin
            wordPlaced[8*((MSB_FIRST != 0) ? (BYTES - 1 - k) : k) +: 8] = rxByte;
         end
      end

      timeoutHit   = (TIMEOUT_BYTES != 0) && (byteCnt_q != '0) && (idleCnt_q == TO_LAST);
      byteCnt_d    = byteCnt_q;
      wordBuf_d    = wordBuf_q;
      dataOut_d    = dataOut_q;
      dataValid_d  = 1'b0;
      frameErr_d   = 1'b0;
      parityErr_d  = 1'b0;
      timeoutErr_d = 1'b0;
      idleCnt_d    = (byteCnt_q != '0) ? (idleCnt_q + 1'b1) : '0;

      if (frameErrRaw || parityErrRaw) begin
         byteCnt_d   = '0;
         idleCnt_d   = '0;
         frameErr_d  = frameErrRaw;
         parityErr_d = parityErrRaw;
      end else if (byteOk) begin
         idleCnt_d = '0;
         if (byteCnt_q == LAST_SLOT) begin
            dataOut_d   = wordPlaced;
            dataValid_d = 1'b1;
            byteCnt_d   = '0;
         end else begin
            wordBuf_d = wordPlaced;
            byteCnt_d = byteCnt_q + 1'b1;
         end
      end else if (timeoutHit) begin
         byteCnt_d    = '0;
         idleCnt_d    = '0;
         timeoutErr_d = 1'b1;
      end
   end

   assign data_out    = dataOut_q;
   assign data_valid  = dataValid_q;
   assign frame_err   = frameErr_q;
   assign parity_err  = parityErr_q;
   assign timeout_err = timeoutErr_q;
   assign byte_cnt    = byteCnt_q;

endmodule
